// File: rtl/demo_sequencer.sv
// Demo-scene timing sequencer: counts video frames, fades each scene in, holds it,
// fades it out and steps to the next scene. Pause gates time to single-step requests.
module demo_sequencer #(
    parameter int NUM_SCENES   = 6,
    parameter int SCENE_FRAMES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_frame,
    input  logic        pause,
    input  logic        advance_frame,
    input  logic        skip,
    output logic        frame_tick,
    output logic [2:0]  scene,
    output logic [7:0]  scene_time,
    output logic [3:0]  fade,
    output logic [15:0] global_frame
);
    typedef enum logic [1:0] {FADE_IN, SHOW, FADE_OUT} state_e;

    localparam logic [7:0] SHOW_END   = 8'(SCENE_FRAMES - 17);
    localparam logic [2:0] LAST_SCENE = 3'(NUM_SCENES - 1);

    state_e      state_q, state_d, eff_state;
    logic [2:0]  scene_q, scene_d;
    logic [7:0]  stime_q, stime_d;
    logic [3:0]  fade_q, fade_d;
    logic [15:0] gframe_q, gframe_d;
    logic        tick_q;
    logic        adv_prev_q, skip_prev_q;
    logic        adv_edge, skip_edge, advance, skip_take;

    assign adv_edge  = advance_frame & ~adv_prev_q;
    assign skip_edge = skip & ~skip_prev_q;
    assign advance   = pause ? adv_edge : new_frame;
    assign skip_take = skip_edge & (state_q != FADE_OUT);
    // A skip landing with an advance is folded in: the advance sees FADE_OUT.
    assign eff_state = skip_take ? FADE_OUT : state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FADE_IN;
            scene_q     <= 3'd0;
            stime_q     <= 8'd0;
            fade_q      <= 4'd0;
            gframe_q    <= 16'd0;
            tick_q      <= 1'b0;
            adv_prev_q  <= 1'b1;
            skip_prev_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            scene_q     <= scene_d;
            stime_q     <= stime_d;
            fade_q      <= fade_d;
            gframe_q    <= gframe_d;
            tick_q      <= advance;
            adv_prev_q  <= advance_frame;
            skip_prev_q <= skip;
        end
    end

    always_comb begin
        state_d = state_q;
        if (advance) begin
            case (eff_state)
                FADE_IN:  if (fade_q == 4'd14) state_d = SHOW;
                SHOW:     if (stime_q == SHOW_END) state_d = FADE_OUT;
                FADE_OUT: state_d = (fade_q == 4'd0) ? FADE_IN : FADE_OUT;
                default:  state_d = FADE_IN;
            endcase
        end else if (skip_take) begin
            state_d = FADE_OUT;
        end
    end

    always_comb begin
        scene_d  = scene_q;
        stime_d  = stime_q;
        fade_d   = fade_q;
        gframe_d = gframe_q;
        if (advance) begin
            gframe_d = gframe_q + 16'd1;
            stime_d  = stime_q + 8'd1;
            case (eff_state)
                FADE_IN: fade_d = fade_q + 4'd1;
                FADE_OUT: begin
                    if (fade_q != 4'd0) begin
                        fade_d = fade_q - 4'd1;
                    end else begin
                        scene_d = (scene_q == LAST_SCENE) ? 3'd0 : scene_q + 3'd1;
                        stime_d = 8'd0;
                    end
                end
                default: fade_d = fade_q;
            endcase
        end
    end

    assign frame_tick   = tick_q;
    assign scene        = scene_q;
    assign scene_time   = stime_q;
    assign fade         = fade_q;
    assign global_frame = gframe_q;
endmodule

// File: tb/tb_demo_sequencer.sv
// Bench for demo_sequencer: two instances (default and small scenes) against a
// phase-level reference model, with expected tick payloads queued for a monitor.
module tb_demo_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1, new_frame = 1'b0, pause = 1'b0, advance_frame = 1'b0, skip = 1'b0;

    logic        tick_o  [2];
    logic [2:0]  scene_o [2];
    logic [7:0]  stime_o [2];
    logic [3:0]  fade_o  [2];
    logic [15:0] gf_o    [2];

    always #5 clk = ~clk;

    demo_sequencer dut_a (
        .clk(clk), .reset(reset), .new_frame(new_frame), .pause(pause),
        .advance_frame(advance_frame), .skip(skip), .frame_tick(tick_o[0]),
        .scene(scene_o[0]), .scene_time(stime_o[0]), .fade(fade_o[0]), .global_frame(gf_o[0])
    );
    demo_sequencer #(.NUM_SCENES(2), .SCENE_FRAMES(32)) dut_b (
        .clk(clk), .reset(reset), .new_frame(new_frame), .pause(pause),
        .advance_frame(advance_frame), .skip(skip), .frame_tick(tick_o[1]),
        .scene(scene_o[1]), .scene_time(stime_o[1]), .fade(fade_o[1]), .global_frame(gf_o[1])
    );

    // Model state: 'out' means the scene is on its way out; "showing" is simply
    // fade at full brightness while not on the way out.
    typedef struct { int scene; int stime; int fade; int gf; bit out; bit pa; bit ps; } mdl_t;
    typedef struct { int scene; int stime; int fade; int gf; } exp_t;

    int    NS [2] = '{6, 2};
    int    SF [2] = '{256, 32};
    mdl_t  m  [2];
    exp_t  q  [2][$];
    int    n_tests = 0, n_fail = 0;
    int    ticks [2] = '{0, 0};

    function automatic mdl_t mstep(input mdl_t c, input int ns, input int sf, input bit rst,
                                   input bit nf, input bit pz, input bit af, input bit sk,
                                   output bit adv);
        mdl_t n;
        bit aedge, sedge;
        n = c;
        adv = 1'b0;
        if (rst) begin
            n.scene = 0; n.stime = 0; n.fade = 0; n.gf = 0; n.out = 1'b0; n.pa = 1'b1; n.ps = 1'b1;
        end else begin
            aedge = af && !c.pa;
            sedge = sk && !c.ps;
            n.pa = af;
            n.ps = sk;
            adv = pz ? aedge : nf;
            if (sedge) n.out = 1'b1;
            if (adv) begin
                n.gf = (c.gf + 1) % 65536;
                if (n.out && c.fade == 0) begin
                    n.scene = (c.scene + 1) % ns;
                    n.stime = 0;
                    n.out = 1'b0;
                end else begin
                    n.stime = (c.stime + 1) % 256;
                    if (n.out) n.fade = c.fade - 1;
                    else if (c.fade < 15) n.fade = c.fade + 1;
                    else if (c.stime == sf - 17) n.out = 1'b1;
                end
            end
        end
        return n;
    endfunction

    task automatic step();
        bit   adv;
        exp_t e;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m[i] = mstep(m[i], NS[i], SF[i], reset, new_frame, pause, advance_frame, skip, adv);
            if (adv) begin
                e.scene = m[i].scene; e.stime = m[i].stime; e.fade = m[i].fade; e.gf = m[i].gf;
                q[i].push_back(e);
            end
        end
        #1;
    endtask

    task automatic pulse();
        new_frame = 1'b1; step();
        new_frame = 1'b0; step();
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step();
        reset = 1'b0;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every frame_tick must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (tick_o[i]) begin
                ticks[i]++;
                n_tests++;
                if (q[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL tick%0d_unexpected: frame_tick=1 expected 0", i);
                end else begin
                    exp_t e;
                    e = q[i].pop_front();
                    if (scene_o[i] != 3'(e.scene) || stime_o[i] != 8'(e.stime) ||
                        fade_o[i] != 4'(e.fade) || gf_o[i] != 16'(e.gf)) begin
                        n_fail++;
                        $display("FAIL tick%0d_payload: got scene=%0d time=%0d fade=%0d gf=%0d expected scene=%0d time=%0d fade=%0d gf=%0d",
                                 i, scene_o[i], stime_o[i], fade_o[i], gf_o[i], e.scene, e.stime, e.fade, e.gf);
                    end
                end
            end else if (q[i].size() != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tick%0d_missing: frame_tick=0 expected 1", i);
                q[i].delete(0);
            end
        end
    end

    initial begin
        int t0;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_scene", scene_o[i], 0);
            chk("rst_time", stime_o[i], 0);
            chk("rst_fade", fade_o[i], 0);
            chk("rst_gf", gf_o[i], 0);
            chk("rst_tick", tick_o[i], 0);
        end

        // Fade-in over 15 frames.
        t0 = ticks[0];
        repeat (15) pulse();
        chk("fadein_fade", fade_o[0], 15);
        chk("fadein_time", stime_o[0], 15);
        chk("fadein_gf", gf_o[0], 15);
        chk("fadein_ticks", ticks[0] - t0, 15);

        // Short scenes: fade-out 15..0 then scene change at pulse 32.
        for (int k = 16; k <= 32; k++) begin
            pulse();
            if (k < 32) chk("fadeout_seq", fade_o[1], 31 - k);
        end
        chk("short_scene", scene_o[1], 1);
        chk("short_time", stime_o[1], 0);
        chk("short_fade", fade_o[1], 0);
        chk("show_hold_fade", fade_o[0], 15);

        // Skip from SHOW at scene_time 40, second skip inside the fade-out.
        repeat (8) pulse();
        chk("pre_skip_time", stime_o[0], 40);
        skip = 1'b1; step(); skip = 1'b0; step();
        chk("skip_fade", fade_o[0], 15);
        chk("skip_time", stime_o[0], 40);
        pulse();
        chk("skip_first_adv", fade_o[0], 14);
        repeat (4) pulse();
        skip = 1'b1; step(); skip = 1'b0; step();
        repeat (11) pulse();
        chk("skip_scene", scene_o[0], 1);
        chk("skip_time0", stime_o[0], 0);
        chk("skip_fade0", fade_o[0], 0);

        // Pause: only advance_frame edges count, coincident new_frame adds nothing.
        do_reset();
        pause = 1'b1;
        repeat (5) pulse();
        chk("pause_nf", gf_o[0], 0);
        repeat (2) begin
            advance_frame = 1'b1; step(); advance_frame = 1'b0; step();
        end
        advance_frame = 1'b1; new_frame = 1'b1; step(); new_frame = 1'b0; step();
        repeat (3) pulse();
        chk("pause_gf", gf_o[0], 3);
        chk("pause_gf_b", gf_o[1], 3);
        advance_frame = 1'b0; pause = 1'b0; step();

        // Scene wrap with two scenes, then global_frame wrap.
        do_reset();
        repeat (32) pulse();
        chk("wrap_scene1", scene_o[1], 1);
        repeat (32) pulse();
        chk("wrap_scene0", scene_o[1], 0);
        do_reset();
        new_frame = 1'b1;
        repeat (65535) step();
        chk("gf_max", gf_o[0], 65535);
        step();
        chk("gf_wrap", gf_o[0], 0);
        new_frame = 1'b0; step();

        // Levels held through reset release give no edge; reset beats an advance.
        reset = 1'b1; advance_frame = 1'b1; skip = 1'b1; step(); step();
        reset = 1'b0; pause = 1'b1; step(); step(); step();
        chk("held_no_edge", gf_o[0], 0);
        advance_frame = 1'b0; skip = 1'b0; pause = 1'b0; step();
        repeat (7) pulse();
        chk("mid_fade", fade_o[0], 7);
        reset = 1'b1; new_frame = 1'b1; skip = 1'b1; step();
        reset = 1'b0; new_frame = 1'b0; skip = 1'b0; step();
        chk("rst2_scene", scene_o[0], 0);
        chk("rst2_time", stime_o[0], 0);
        chk("rst2_fade", fade_o[0], 0);
        chk("rst2_gf", gf_o[0], 0);
        chk("rst2_tick", tick_o[0], 0);
        pulse();
        chk("post_rst_fade", fade_o[0], 1);
        chk("post_rst_gf", gf_o[0], 1);

        // Random traffic.
        for (int n = 0; n < 4000; n++) begin
            reset     = ($urandom_range(0, 499) == 0);
            new_frame = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            if ($urandom_range(0, 3) == 0) advance_frame = ~advance_frame;
            if ($urandom_range(0, 29) == 0) skip = ~skip;
            step();
        end
        reset = 1'b0; new_frame = 1'b0; step(); step();
        @(negedge clk); #1;
        chk("queue_a_empty", q[0].size(), 0);
        chk("queue_b_empty", q[1].size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/demo_sequencer.md
DEMO_SEQUENCER -- requirements
Module: demo_sequencer

Interface
REQ-001 The module SHALL have parameter NUM_SCENES, default 6, meaning the number of scenes, legal range 2..8.
REQ-002 The module SHALL have parameter SCENE_FRAMES, default 256, meaning frames per scene when not skipped, legal range 32..256.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-005 Port new_frame SHALL be an input, 1 bit: one-cycle pulse at the start of each video frame.
REQ-006 Port pause SHALL be an input, 1 bit: level; while high, time advances only by single-step.
REQ-007 Port advance_frame SHALL be an input, 1 bit: level; each rising edge is a single-step request.
REQ-008 Port skip SHALL be an input, 1 bit: level; each rising edge requests an early fade-out of the current scene.
REQ-009 Port frame_tick SHALL be an output, 1 bit: one-cycle pulse marking that the time registers were just updated.
REQ-010 Port scene SHALL be an output, 3 bits: current scene index.
REQ-011 Port scene_time SHALL be an output, 8 bits: frames elapsed in the current scene.
REQ-012 Port fade SHALL be an output, 4 bits: brightness level, 0 = black, 15 = full.
REQ-013 Port global_frame SHALL be an output, 16 bits: total number of advances since reset.

Function
REQ-014 advance_frame and skip SHALL each be registered once into a prev flop; an edge is input high AND prev low.
REQ-015 An advance SHALL occur in a cycle when new_frame is high and pause is low, or when pause is high and an advance_frame edge is detected.
REQ-016 new_frame and an advance_frame edge in the same cycle SHALL produce exactly one advance.
REQ-017 advance_frame edges while pause is low SHALL be ignored.
REQ-018 Each advance SHALL update all time registers at the next rising edge; frame_tick SHALL be high for exactly that following cycle.
REQ-019 Every advance SHALL increment global_frame modulo 2^16, so 65535 wraps to 0.
REQ-020 Every advance SHALL increment scene_time modulo 256, except on a scene change, where scene_time becomes 0.
REQ-021 The state machine SHALL have exactly three states: FADE_IN, SHOW and FADE_OUT.
REQ-022 On an advance in FADE_IN, fade SHALL become fade+1, and the state SHALL become SHOW when the new fade is 15.
REQ-023 On an advance in SHOW with scene_time == SCENE_FRAMES-17, the state SHALL become FADE_OUT and fade SHALL stay 15.
REQ-024 On an advance in FADE_OUT with fade > 0, fade SHALL become fade-1.
REQ-025 On an advance in FADE_OUT with fade == 0, the block SHALL perform a scene change: scene becomes scene+1 (NUM_SCENES-1 wraps to 0), scene_time becomes 0, fade stays 0, and the state becomes FADE_IN.
REQ-026 Without skip, each scene SHALL last exactly SCENE_FRAMES advances, and fade SHALL equal scene_time for scene_time values 0..15.
REQ-027 A skip edge in FADE_IN or SHOW SHALL move the state to FADE_OUT at the next edge, with fade and scene_time unchanged by the skip itself.
REQ-028 A skip edge in FADE_OUT SHALL be ignored.
REQ-029 When a skip edge and an advance coincide, the advance SHALL be processed as if the state were already FADE_OUT: fade decrements, or a scene change occurs if fade == 0.
REQ-030 pause SHALL never alter any state register; it SHALL only gate advances.

Reset
REQ-031 While reset is high at a clock edge, the block SHALL set scene=0, scene_time=0, fade=0, global_frame=0, frame_tick=0 and state=FADE_IN.
REQ-032 During reset, both prev flops SHALL be set to 1, so an input held high through reset generates no edge.
REQ-033 Reset asserted mid-scene or mid-fade SHALL take priority over every simultaneous advance or skip; the first advance after release SHALL start from the reset values.

Verification
REQ-034 Bench scenario: reset, then 15 new_frame pulses with pause=0 -> fade=15, state SHOW, scene_time=15, global_frame=15, and one frame_tick per pulse.
REQ-035 Bench scenario: SCENE_FRAMES=32 and 32 new_frame pulses -> scene=1, scene_time=0, fade=0; the fade sequence over pulses 16..31 is 15,14,...,0.
REQ-036 Bench scenario: pause=1, 5 new_frame pulses, then 3 advance_frame rising edges, one landing in the same cycle as a new_frame -> global_frame=3, and advance_frame held high produces no repeat.
REQ-037 Bench scenario: in SHOW at scene_time=40, a skip edge -> FADE_OUT with fade=15; after 16 more advances -> scene+1, scene_time=0; a second skip during that FADE_OUT has no effect.
REQ-038 Bench scenario: NUM_SCENES=2, run through 2 full scenes -> scene wraps 1->0; preload global_frame to 65535 -> the next advance gives 0.
REQ-039 Bench scenario: advance_frame and skip held high across reset release, then reset pulsed mid-FADE_IN at fade=7 -> no edge fires after release, and all outputs return to the reset values of REQ-031.
